// File: rtl/game_settings_if.sv
// ---------------------------------------------------------------------------
// game_settings_if
//   Bundle of signals between the menu / main game FSM (master) and the
//   game_settings block (slave).
//
//   Master -> slave : level_sel[1:0], level_valid, start, pause, stop
//   Slave -> master : cfg_valid, row_col_num[3:0], mine_num[5:0],
//                     field_size[6:0], board_size[10:0], board_xpos[10:0],
//                     board_ypos[10:0], timer_sec[6:0], timer_running, timeout
// ---------------------------------------------------------------------------
interface game_settings_if;
    logic [1:0]  level_sel;
    logic        level_valid;
    logic        start;
    logic        pause;
    logic        stop;

    logic        cfg_valid;
    logic [3:0]  row_col_num;
    logic [5:0]  mine_num;
    logic [6:0]  field_size;
    logic [10:0] board_size;
    logic [10:0] board_xpos;
    logic [10:0] board_ypos;
    logic [6:0]  timer_sec;
    logic        timer_running;
    logic        timeout;

    modport master (
        output level_sel, level_valid, start, pause, stop,
        input  cfg_valid, row_col_num, mine_num, field_size, board_size,
               board_xpos, board_ypos, timer_sec, timer_running, timeout
    );

    modport slave (
        input  level_sel, level_valid, start, pause, stop,
        output cfg_valid, row_col_num, mine_num, field_size, board_size,
               board_xpos, board_ypos, timer_sec, timer_running, timeout
    );
endinterface

// File: rtl/game_settings.sv
// ---------------------------------------------------------------------------
// game_settings
//   Latches the menu-selected difficulty into registered board settings and
//   owns the per-game countdown timer with a one-cycle timeout pulse.
//
//   Ports:
//     clk  - system pixel clock, all logic on the rising edge
//     rst  - synchronous, active-high reset
//     bus  - game_settings_if.slave (level select / start / pause / stop in,
//            board settings, timer_sec, timer_running, timeout out)
//
//   Parameters:
//     TICK_DIV  - clk cycles per timer second (2 .. 2^27-1)
//     X_CENTER  - screen X center the board is centred on
//     Y_CENTER  - screen Y center the board is centred on
//
//   Build option:
//     GAME_TIMER_EN - when defined, the countdown timer runs; when undefined,
//                     timer_sec holds the loaded seconds and timeout is 0.
// ---------------------------------------------------------------------------
module game_settings #(
    parameter int unsigned TICK_DIV = 65_000_000,
    parameter int unsigned X_CENTER = 512,
    parameter int unsigned Y_CENTER = 480
) (
    input  logic            clk,
    input  logic            rst,
    game_settings_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_LOADED, S_RUN, S_HOLD, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] row_col_num;
        logic [5:0] mine_num;
        logic [6:0] seconds;
    } level_cfg_t;

    localparam logic [6:0] FIELD_SIZE = 7'd64;

    if (TICK_DIV < 2 || TICK_DIV > 27'h7FF_FFFF) begin : g_bad_tick_div
        $error("game_settings: TICK_DIV out of range");
    end

    function automatic level_cfg_t level_lookup(input logic [1:0] sel);
        case (sel)
            2'b01:   level_lookup = '{row_col_num: 4'd8,  mine_num: 6'd19, seconds: 7'd45};
            2'b10:   level_lookup = '{row_col_num: 4'd10, mine_num: 6'd30, seconds: 7'd50};
            2'b11:   level_lookup = '{row_col_num: 4'd15, mine_num: 6'd40, seconds: 7'd70};
            default: level_lookup = '{row_col_num: 4'd0,  mine_num: 6'd0,  seconds: 7'd0};
        endcase
    endfunction

    state_t      r_state;
    logic        r_cfg_valid;
    logic [3:0]  r_row_col_num;
    logic [5:0]  r_mine_num;
    logic [6:0]  r_field_size;
    logic [10:0] r_board_size;
    logic [10:0] r_board_xpos;
    logic [10:0] r_board_ypos;
    logic [6:0]  r_seed;
    logic [6:0]  r_timer_sec;
    logic        r_timer_running;

    level_cfg_t  w_cfg;
    logic        w_load;
    logic        w_do_load;
    logic [10:0] w_board_size;
    logic [11:0] w_half;
    logic [10:0] w_board_xpos;
    logic [10:0] w_board_ypos;

    assign w_cfg        = level_lookup(bus.level_sel);
    assign w_load       = bus.level_valid && (bus.level_sel != 2'b00);
    // Loads are honoured everywhere except while a game is in play.
    assign w_do_load    = w_load && (r_state == S_IDLE || r_state == S_LOADED ||
                                     r_state == S_DONE);
    assign w_board_size = 11'(w_cfg.row_col_num) * 11'(FIELD_SIZE);
    // Position is centre minus half the board, formed in 12-bit signed and
    // truncated; the level table keeps the result non-negative.
    assign w_half       = {2'b00, w_board_size[10:1]};
    assign w_board_xpos = 11'($signed(12'(X_CENTER)) - $signed(w_half));
    assign w_board_ypos = 11'($signed(12'(Y_CENTER)) - $signed(w_half));

    // NOTE: every register is cleared by the synchronous reset and updated
    // with non-blocking assignments so all readers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_valid   <= 1'b0;
            r_row_col_num <= '0;
            r_mine_num    <= '0;
            r_field_size  <= '0;
            r_board_size  <= '0;
            r_board_xpos  <= '0;
            r_board_ypos  <= '0;
            r_seed        <= '0;
        end else if (w_do_load) begin
            r_cfg_valid   <= 1'b1;
            r_row_col_num <= w_cfg.row_col_num;
            r_mine_num    <= w_cfg.mine_num;
            r_field_size  <= FIELD_SIZE;
            r_board_size  <= w_board_size;
            r_board_xpos  <= w_board_xpos;
            r_board_ypos  <= w_board_ypos;
            r_seed        <= w_cfg.seconds;
        end
    end

`ifdef GAME_TIMER_EN
    localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);

    logic [26:0] r_presc;
    logic        r_timeout;
    logic        w_run_count;
    logic        w_tick;

    // stop and pause take priority over counting; the prescaler only
    // advances on a plain RUN cycle.
    assign w_run_count = (r_state == S_RUN) && !bus.stop && !bus.pause;
    assign w_tick      = w_run_count && (r_presc == TICK_LAST);

    // Held in HOLD so a pause resumes mid-second; zero outside a game so
    // every entry into RUN starts a fresh second.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_run_count) begin
            r_presc <= w_tick ? '0 : r_presc + 27'd1;
        end else if (r_state != S_RUN && r_state != S_HOLD) begin
            r_presc <= '0;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_timer_sec     <= '0;
            r_timer_running <= 1'b0;
`ifdef GAME_TIMER_EN
            r_timeout       <= 1'b0;
`endif
        end else begin
`ifdef GAME_TIMER_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state     <= S_LOADED;
                        r_timer_sec <= w_cfg.seconds;
                    end
                end
                S_LOADED: begin
                    if (w_load) begin
                        r_timer_sec <= w_cfg.seconds;
                    end else if (bus.start) begin
                        r_state         <= S_RUN;
                        r_timer_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_state         <= S_DONE;
                        r_timer_running <= 1'b0;
                    end else if (bus.pause) begin
                        r_state         <= S_HOLD;
                        r_timer_running <= 1'b0;
                    end
`ifdef GAME_TIMER_EN
                    else if (w_tick) begin
                        if (r_timer_sec <= 7'd1) begin
                            r_timer_sec     <= '0;
                            r_timeout       <= (r_timer_sec == 7'd1);
                            r_state         <= S_DONE;
                            r_timer_running <= 1'b0;
                        end else begin
                            r_timer_sec <= r_timer_sec - 7'd1;
                        end
                    end
`endif
                end
                S_HOLD: begin
                    if (bus.stop) begin
                        r_state <= S_DONE;
                    end else if (!bus.pause) begin
                        r_state         <= S_RUN;
                        r_timer_running <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_load) begin
                        r_state     <= S_LOADED;
                        r_timer_sec <= w_cfg.seconds;
                    end else if (bus.start) begin
                        r_state         <= S_RUN;
                        r_timer_sec     <= r_seed;
                        r_timer_running <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_timer_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_valid     = r_cfg_valid;
    assign bus.row_col_num   = r_row_col_num;
    assign bus.mine_num      = r_mine_num;
    assign bus.field_size    = r_field_size;
    assign bus.board_size    = r_board_size;
    assign bus.board_xpos    = r_board_xpos;
    assign bus.board_ypos    = r_board_ypos;
    assign bus.timer_sec     = r_timer_sec;
    assign bus.timer_running = r_timer_running;

endmodule

// File: tb/tb_game_settings.sv
// ---------------------------------------------------------------------------
// tb_game_settings
//   Self-checking bench for game_settings: directed scenarios followed by
//   randomized stimulus, every cycle compared against a behavioural model
//   that tracks elapsed counting cycles rather than a prescaler.
// ---------------------------------------------------------------------------
module tb_game_settings;

    localparam int unsigned TICK_DIV = 10;
    localparam int          X_C      = 512;
    localparam int          Y_C      = 480;

    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_HOLD = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic rst;

    game_settings_if bus();

    game_settings #(
        .TICK_DIV (TICK_DIV),
        .X_CENTER (X_C),
        .Y_CENTER (Y_C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int rc_tab[4]    = '{0, 8, 10, 15};
    int mine_tab[4]  = '{0, 19, 30, 40};
    int secs_tab[4]  = '{0, 45, 50, 70};

    // Model: mode, selected level, and number of cycles the timer has counted.
    int m_mode  = M_IDLE;
    int m_level = 0;
    int m_count = 0;
    bit m_valid = 1'b0;
    bit m_timeout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_timer();
        if (!m_valid) return 0;
`ifdef GAME_TIMER_EN
        return secs_tab[m_level] - m_count / int'(TICK_DIV);
`else
        return secs_tab[m_level];
`endif
    endfunction

    task automatic model_load(input int lvl);
        m_level = lvl;
        m_valid = 1'b1;
        m_count = 0;
    endtask

    task automatic model_update();
        bit lv_ok;
        lv_ok     = bus.level_valid && (bus.level_sel != 2'b00);
        m_timeout = 1'b0;
        if (rst) begin
            m_mode  = M_IDLE;
            m_valid = 1'b0;
            m_level = 0;
            m_count = 0;
        end else begin
            case (m_mode)
                M_IDLE:   if (lv_ok) begin model_load(int'(bus.level_sel)); m_mode = M_LOADED; end
                M_LOADED: if (lv_ok) model_load(int'(bus.level_sel));
                          else if (bus.start) begin m_mode = M_RUN; m_count = 0; end
                M_RUN: begin
                    if (bus.stop) m_mode = M_DONE;
                    else if (bus.pause) m_mode = M_HOLD;
                    else begin
`ifdef GAME_TIMER_EN
                        m_count++;
                        if (m_count == secs_tab[m_level] * int'(TICK_DIV)) begin
                            m_timeout = 1'b1;
                            m_mode    = M_DONE;
                        end
`endif
                    end
                end
                M_HOLD:   if (bus.stop) m_mode = M_DONE;
                          else if (!bus.pause) m_mode = M_RUN;
                M_DONE:   if (lv_ok) begin model_load(int'(bus.level_sel)); m_mode = M_LOADED; end
                          else if (bus.start) begin m_mode = M_RUN; m_count = 0; end
                default:  m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        int board;
        board = m_valid ? rc_tab[m_level] * 64 : 0;
        check("cfg_valid",     32'(bus.cfg_valid),     32'(m_valid));
        check("row_col_num",   32'(bus.row_col_num),   32'(m_valid ? rc_tab[m_level] : 0));
        check("mine_num",      32'(bus.mine_num),      32'(m_valid ? mine_tab[m_level] : 0));
        check("field_size",    32'(bus.field_size),    32'(m_valid ? 64 : 0));
        check("board_size",    32'(bus.board_size),    32'(board));
        check("board_xpos",    32'(bus.board_xpos),    32'(m_valid ? X_C - board / 2 : 0));
        check("board_ypos",    32'(bus.board_ypos),    32'(m_valid ? Y_C - board / 2 : 0));
        check("timer_sec",     32'(bus.timer_sec),     32'(exp_timer()));
        check("timer_running", 32'(bus.timer_running), 32'(m_mode == M_RUN));
        check("timeout",       32'(bus.timeout),       32'(m_timeout));
    endtask

    // One clock: the model consumes the inputs of this edge, outputs are
    // sampled 1 ns later, and the caller may then change inputs.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic strobe_level(input logic [1:0] sel);
        bus.level_valid = 1'b1;
        bus.level_sel   = sel;
        step();
        bus.level_valid = 1'b0;
    endtask

    task automatic strobe_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        int tcount;
        int tfirst;

        rst             = 1'b1;
        bus.level_sel   = 2'b00;
        bus.level_valid = 1'b0;
        bus.start       = 1'b0;
        bus.pause       = 1'b0;
        bus.stop        = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_cfg_valid", 32'(bus.cfg_valid), 32'd0);
        check("reset_timer_sec", 32'(bus.timer_sec), 32'd0);

        // Easy load, visible the next cycle.
        strobe_level(2'b01);
        check("easy_row_col", 32'(bus.row_col_num), 32'd8);
        check("easy_mines",   32'(bus.mine_num),    32'd19);
        check("easy_board",   32'(bus.board_size),  32'd512);
        check("easy_timer",   32'(bus.timer_sec),   32'd45);
        check("easy_running", 32'(bus.timer_running), 32'd0);

        // Hard, then medium reload while LOADED, then an invalid strobe.
        strobe_level(2'b11);
        check("hard_board",   32'(bus.board_size),  32'd960);
        check("hard_xpos",    32'(bus.board_xpos),  32'd32);
        strobe_level(2'b10);
        check("med_row_col",  32'(bus.row_col_num), 32'd10);
        check("med_mines",    32'(bus.mine_num),    32'd30);
        check("med_board",    32'(bus.board_size),  32'd640);
        check("med_timer",    32'(bus.timer_sec),   32'd50);
        strobe_level(2'b00);
        check("invalid_keep", 32'(bus.row_col_num), 32'd10);

`ifdef GAME_TIMER_EN
        // Full easy game: first decrement and timeout timing.
        strobe_level(2'b01);
        strobe_start();
        check("run_entry", 32'(bus.timer_running), 32'd1);
        n = 0;
        tcount = 0;
        tfirst = 0;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (n == 0 && bus.timer_sec == 7'd44) n = i;
            if (bus.timeout) begin
                tcount++;
                if (tfirst == 0) tfirst = i;
            end
        end
        check("first_tick_cycles", 32'(n), 32'd10);
        check("timeout_pulses",    32'(tcount), 32'd1);
        check("timeout_cycle",     32'(tfirst), 32'd450);
        check("done_timer",        32'(bus.timer_sec), 32'd0);
        check("done_running",      32'(bus.timer_running), 32'd0);

        // Pause of 37 cycles three cycles into the first second.
        strobe_level(2'b01);
        strobe_start();
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            bus.pause = (i >= 4 && i <= 40);
            step();
            if (bus.timer_sec == 7'd44) begin
                n = i;
                break;
            end
        end
        bus.pause = 1'b0;
        check("pause_tick_period", 32'(n), 32'd48);

        // stop on the very edge that would have produced the timeout.
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (m_count == 45 * int'(TICK_DIV) - 1) begin
                bus.stop = 1'b1;
                step();
                bus.stop = 1'b0;
                n = 1;
                break;
            end
            step();
        end
        check("stop_reached",  32'(n), 32'd1);
        check("stop_timer",    32'(bus.timer_sec), 32'd1);
        check("stop_timeout",  32'(bus.timeout), 32'd0);
        check("stop_running",  32'(bus.timer_running), 32'd0);
        step();
        check("stop_no_late_timeout", 32'(bus.timeout), 32'd0);
        strobe_start();
        check("reseed_timer",   32'(bus.timer_sec), 32'd45);
        check("reseed_running", 32'(bus.timer_running), 32'd1);
`else
        // Timer disabled: timer_sec stays at the seed and timeout stays low.
        strobe_level(2'b01);
        strobe_start();
        n = 0;
        tcount = 0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
            step();
            if (bus.timer_sec != 7'd45) n++;
            if (bus.timeout) tcount++;
        end
        bus.pause = 1'b0;
        step();
        check("notimer_changes", 32'(n), 32'd0);
        check("notimer_timeout", 32'(tcount), 32'd0);
        check("notimer_running", 32'(bus.timer_running), 32'd1);
`endif

        // Reset in RUN clears everything on the next edge.
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_cfg_valid",  32'(bus.cfg_valid),     32'd0);
        check("rst_row_col",    32'(bus.row_col_num),   32'd0);
        check("rst_mines",      32'(bus.mine_num),      32'd0);
        check("rst_field",      32'(bus.field_size),    32'd0);
        check("rst_board",      32'(bus.board_size),    32'd0);
        check("rst_xpos",       32'(bus.board_xpos),    32'd0);
        check("rst_ypos",       32'(bus.board_ypos),    32'd0);
        check("rst_timer",      32'(bus.timer_sec),     32'd0);
        check("rst_running",    32'(bus.timer_running), 32'd0);
        check("rst_timeout",    32'(bus.timeout),       32'd0);

        // Randomized traffic, every cycle checked against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.level_valid = ($urandom_range(0, 29) == 0);
            bus.level_sel   = 2'($urandom_range(0, 3));
            bus.start       = ($urandom_range(0, 24) == 0);
            bus.stop        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) bus.pause = ~bus.pause;
            rst             = ($urandom_range(0, 999) == 0);
            step();
        end
        rst             = 1'b0;
        bus.level_valid = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.pause       = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
